// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: state encoding,
// PC/instruction widths, HALT opcode field location and IF/ID bundle layout.
package fetch_pkg;

  localparam int PC_W     = 16;
  localparam int INSTR_W  = 16;
  localparam int BUNDLE_W = PC_W + INSTR_W;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] HALT_OPCODE_DEFAULT = 5'b00000;

  // IF/ID bundle is {pc_plus2, instr}
  localparam int BUNDLE_PC_LSB    = INSTR_W;
  localparam int BUNDLE_INSTR_LSB = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: 16-bit enabled register with synchronous reset to RESET_PC.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [PC_W-1:0] d,
  output logic [PC_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with one-entry hold buffer for IF/ID stalls and HALT decode.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]  RESET_PC    = 16'h0000,
  parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_rdy,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [BUNDLE_W-1:0] ifid_bundle,
  output logic                ifid_we,
  output logic                halted,
  output logic [15:0]         fetch_cnt,
  output logic [15:0]         stall_cnt
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ibuf_q, ibuf_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               pc_en;
  logic [PC_W-1:0]    pc_plus2;
  logic [INSTR_W-1:0] instr;
  logic               is_halt;
  logic               deliver;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc_q)
  );

  assign pc_plus2  = pc_q + PC_W'(2);
  assign instr     = (state_q == ST_HOLD) ? ibuf_q : imem_data;
  assign is_halt   = (instr[OPC_HI:OPC_LO] == HALT_OPCODE);
  assign imem_addr = pc_q;
  assign ifid_bundle[BUNDLE_PC_LSB +: PC_W]       = pc_plus2;
  assign ifid_bundle[BUNDLE_INSTR_LSB +: INSTR_W] = instr;

  always_comb begin
    imem_req = 1'b0;
    ifid_we  = 1'b0;
    halted   = 1'b0;
    deliver  = 1'b0;
    pc_en    = 1'b0;
    pc_d     = pc_q;
    state_d  = state_q;
    ibuf_d   = ibuf_q;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          imem_req = 1'b1;
          if (imem_rdy && !redirect) begin
            if (!stall) begin
              deliver = 1'b1;
            end else begin
              ibuf_d  = imem_data;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall && !redirect) begin
            deliver = 1'b1;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
      if (deliver) begin
        ifid_we = 1'b1;
        pc_en   = 1'b1;
        pc_d    = pc_plus2;
        state_d = is_halt ? ST_HALT : ST_RUN;
      end
      // A resolved branch wins over everything: drop buffered and in-flight data.
      if (redirect) begin
        pc_en   = 1'b1;
        pc_d    = redirect_pc;
        state_d = ST_RUN;
        ibuf_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ibuf_q  <= '0;
    end else begin
      state_q <= state_d;
      ibuf_q  <= ibuf_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_cycle;

  always_comb begin
    stall_cycle = !rst && (((state_q == ST_RUN) && !imem_rdy) || (state_q == ST_HOLD));
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (ifid_we && (fetch_cnt_q != 16'hFFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
    if (stall_cycle && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = 16'h0000;
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations
// followed by randomized traffic, all compared against a behavioural fetch model.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [4:0]  HALT_OP  = 5'b00000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_rdy;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_req, ifid_we, halted;
  logic [15:0] imem_addr, fetch_cnt, stall_cnt;
  logic [31:0] ifid_bundle;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .RESET_PC    (RESET_PC),
    .HALT_OPCODE (HALT_OP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .ifid_bundle (ifid_bundle),
    .ifid_we     (ifid_we),
    .halted      (halted),
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: where fetch is, whether an instruction is parked, whether stopped.
  logic [15:0] m_pc;
  bit          m_parked;
  logic [15:0] m_parked_instr;
  bit          m_stopped;
  int          m_fetches;
  int          m_stalls;

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs this cycle from model state and current inputs.
  task automatic expect_outputs(output bit e_req, output bit e_we, output bit e_halted,
                                output logic [31:0] e_bundle);
    logic [15:0] word;
    bit          running;
    running  = !m_parked && !m_stopped;
    word     = m_parked ? m_parked_instr : imem_data;
    e_req    = !rst && running;
    e_halted = !rst && m_stopped;
    e_we     = !rst && !redirect && !stall && (m_parked || (running && imem_rdy));
    e_bundle = {m_pc + 16'd2, word};
  endtask

  task automatic compare_all();
    bit          e_req, e_we, e_halted;
    logic [31:0] e_bundle;
    expect_outputs(e_req, e_we, e_halted, e_bundle);
    check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    check("ifid_we", {31'b0, ifid_we}, {31'b0, e_we});
    check("halted", {31'b0, halted}, {31'b0, e_halted});
    check("imem_addr", {16'b0, imem_addr}, {16'b0, m_pc});
    if (e_we) check("ifid_bundle", ifid_bundle, e_bundle);
`ifdef FETCH_STATS_EN
    check("fetch_cnt", {16'b0, fetch_cnt}, {16'b0, sat16(m_fetches)});
    check("stall_cnt", {16'b0, stall_cnt}, {16'b0, sat16(m_stalls)});
`else
    check("fetch_cnt", {16'b0, fetch_cnt}, 32'h0);
    check("stall_cnt", {16'b0, stall_cnt}, 32'h0);
`endif
  endtask

  task automatic model_advance();
    bit          e_req, e_we, e_halted;
    logic [31:0] e_bundle;
    bit          running;
    expect_outputs(e_req, e_we, e_halted, e_bundle);
    running = !m_parked && !m_stopped;
    if (rst) begin
      m_pc = RESET_PC; m_parked = 0; m_parked_instr = '0; m_stopped = 0;
      m_fetches = 0; m_stalls = 0;
      return;
    end
    if (e_we) m_fetches++;
    if ((running && !imem_rdy) || m_parked) m_stalls++;
    if (redirect) begin
      m_pc = redirect_pc; m_parked = 0; m_stopped = 0;
    end else if (e_we) begin
      m_pc      = m_pc + 16'd2;
      m_stopped = (e_bundle[15:11] == HALT_OP);
      m_parked  = 0;
    end else if (running && imem_rdy && stall) begin
      m_parked = 1; m_parked_instr = imem_data;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic drive(input bit r, input bit s, input bit rd, input logic [15:0] rpc,
                       input bit rdy, input logic [15:0] data);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; imem_rdy = rdy; imem_data = data;
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 16'h0, 1, 16'h4A21);
    step();
  endtask

  initial begin
    m_pc = 16'hxxxx; m_parked = 0; m_parked_instr = '0; m_stopped = 0;
    m_fetches = 0; m_stalls = 0;
    @(posedge clk); #1;

    // Reset cycle: control outputs forced low.
    drive(1, 0, 0, 16'h0, 1, 16'h4A21);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_we", {31'b0, ifid_we}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    step();

    // Zero-wait stream of 16'h4A21.
    drive(0, 0, 0, 16'h0, 1, 16'h4A21);
    check("zw_addr0", {16'b0, imem_addr}, 32'h0000);
    check("zw_bundle0", ifid_bundle, 32'h0002_4A21);
    step();
    check("zw_addr1", {16'b0, imem_addr}, 32'h0002);
    check("zw_bundle1", ifid_bundle, 32'h0004_4A21);
    step();
    check("zw_addr2", {16'b0, imem_addr}, 32'h0004);
    step();

    // Three stalled cycles at 0x0010, then release from the hold buffer.
    do_reset();
    drive(0, 0, 1, 16'h0010, 1, 16'h4A21);
    step();
    drive(0, 1, 0, 16'h0, 1, 16'h7B33);
    check("st_addr", {16'b0, imem_addr}, 32'h0010);
    check("st_we0", {31'b0, ifid_we}, 32'h0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 16'h0, 1, 16'h1111);
      check("hold_req", {31'b0, imem_req}, 32'h0);
      check("hold_we", {31'b0, ifid_we}, 32'h0);
      step();
    end
    drive(0, 0, 0, 16'h0, 0, 16'h2222);
    check("hold_rel_we", {31'b0, ifid_we}, 32'h1);
    check("hold_rel_bundle", ifid_bundle, 32'h0012_7B33);
    step();
`ifdef FETCH_STATS_EN
    check("hold_stall_cnt", {16'b0, stall_cnt}, 32'd3);
`endif

    // Redirect beats stall and ready in the same cycle.
    drive(0, 1, 1, 16'h0100, 1, 16'h4A21);
    check("rd_we", {31'b0, ifid_we}, 32'h0);
    step();
    drive(0, 0, 0, 16'h0, 0, 16'h4A21);
    check("rd_addr", {16'b0, imem_addr}, 32'h0100);
    check("rd_no_hold", {31'b0, imem_req}, 32'h1);
    step();

    // HALT fetched at 0x0020, then redirect out of HALT.
    drive(0, 0, 1, 16'h0020, 0, 16'h4A21);
    step();
    drive(0, 0, 0, 16'h0, 1, 16'h0000);
    check("halt_bundle", ifid_bundle, 32'h0022_0000);
    check("halt_we", {31'b0, ifid_we}, 32'h1);
    step();
    drive(0, 0, 0, 16'h0, 1, 16'h4A21);
    check("halted", {31'b0, halted}, 32'h1);
    check("halt_req", {31'b0, imem_req}, 32'h0);
    check("halt_we0", {31'b0, ifid_we}, 32'h0);
    step();
    drive(0, 0, 1, 16'h0040, 0, 16'h4A21);
    step();
    drive(0, 0, 0, 16'h0, 0, 16'h4A21);
    check("unhalt_addr", {16'b0, imem_addr}, 32'h0040);
    check("unhalt_halted", {31'b0, halted}, 32'h0);
    step();

    // PC wrap at 0xFFFE.
    drive(0, 0, 1, 16'hFFFE, 0, 16'h4A21);
    step();
    drive(0, 0, 0, 16'h0, 1, 16'h4A21);
    check("wrap_bundle", ifid_bundle, 32'h0000_4A21);
    step();
    check("wrap_addr", {16'b0, imem_addr}, 32'h0000);
    step();

    // Reset while holding.
    drive(0, 1, 0, 16'h0, 1, 16'h5555);
    step();
    drive(0, 1, 0, 16'h0, 0, 16'h5555);
    step();
    drive(1, 1, 0, 16'h0, 0, 16'h5555);
    step();
    drive(0, 0, 0, 16'h0, 0, 16'h5555);
    check("rsthold_addr", {16'b0, imem_addr}, {16'b0, RESET_PC});
    check("rsthold_req", {31'b0, imem_req}, 32'h1);
    check("rsthold_fcnt", {16'b0, fetch_cnt}, 32'h0);
    check("rsthold_scnt", {16'b0, stall_cnt}, 32'h0);
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 9) == 0) d[15:11] = HALT_OP;
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 6,
            16'($urandom),
            $urandom_range(0, 99) < 70,
            d);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
